sw_debounce: RTL and testbench

- Input conditioning stage directly upstream of the switch display block.
- Takes the raw, asynchronous, bouncing active-low board switches.
- Synchronises each bit into clk, debounces it, and delivers a stable switch vector.
- Also delivers one-cycle change pulses, so the display stage only ever sees clean, settled values.

---
 rtl/sw_debounce.sv | 91 +++++++++
 tb/tb_sw_debounce.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
`timescale 1ns/1ps
// Two-flop synchroniser plus per-bit debounce for active-low board switches.
// Define SW_DEB_BYPASS_EN to drop the counters (sw_clean follows sync2) for fast simulation.
module sw_debounce #(
    parameter int unsigned     WIDTH      = 4,
    parameter int unsigned     DEB_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_chg,
    output logic             sw_any_chg
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_chg;
    logic             r_any_chg;

    logic [WIDTH-1:0] w_clean_d;
    logic [WIDTH-1:0] w_chg_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SW_DEB_BYPASS_EN
    always_comb begin
        w_clean_d = r_sync2;
        w_chg_d   = r_sync2 ^ r_clean;
    end
`else
    localparam int unsigned       CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0][CNT_W-1:0] w_cnt_d;

    // Any sample that agrees with sw_clean restarts that bit's qualification window.
    always_comb begin
        w_clean_d = r_clean;
        w_chg_d   = '0;
        w_cnt_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] != r_clean[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_clean_d[i] = r_sync2[i];
                    w_chg_d[i]   = 1'b1;
                    w_cnt_d[i]   = '0;
                end else begin
                    w_cnt_d[i]   = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clean   <= RST_VAL;
            r_chg     <= '0;
            r_any_chg <= 1'b0;
        end else begin
            r_clean   <= w_clean_d;
            r_chg     <= w_chg_d;
            r_any_chg <= |w_chg_d;
        end
    end

    assign sw_clean   = r_clean;
    assign sw_chg     = r_chg;
    assign sw_any_chg = r_any_chg;

endmodule

// File: tb/tb_sw_debounce.sv
`timescale 1ns/1ps
// Scoreboard bench for sw_debounce: stimulus pushes expected change pulses with their
// due cycle; a negedge monitor pops and compares whenever a change pulse appears.
module tb_sw_debounce;

    localparam int WIDTH = 4;
    localparam int DEB   = 8;
`ifdef SW_DEB_BYPASS_EN
    localparam int LAT = 3;
`else
    localparam int LAT = DEB + 2;
`endif

    logic             clk    = 1'b0;
    logic             resetn = 1'b0;
    logic [WIDTH-1:0] sw_raw = 4'hf;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_chg;
    logic             sw_any_chg;

    sw_debounce #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB),
        .RST_VAL    (4'hf)
    ) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_chg     (sw_chg),
        .sw_any_chg (sw_any_chg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] clean;
        logic [WIDTH-1:0] chg;
        int               at;
    } exp_t;

    exp_t             q[$];
    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] acc    = 4'hf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] clean, input logic [WIDTH-1:0] chg,
                        input int at);
        exp_t e;
        e.clean = clean;
        e.chg   = chg;
        e.at    = at;
        q.push_back(e);
    endtask

    // Debounced build: only a held ("settle") level is expected to be accepted.
    // Bypass build: every level change is expected to pass through.
    task automatic drive(input logic [WIDTH-1:0] v, input bit settle);
        sw_raw = v;
`ifdef SW_DEB_BYPASS_EN
        if (v != acc) push(v, v ^ acc, cyc + LAT);
        acc = v;
`else
        if (settle) begin
            push(v, v ^ acc, cyc + LAT);
            acc = v;
        end
`endif
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            check("missed_pulse_cycle", 32'(cyc), 32'(e.at));
        end
        if (sw_any_chg || sw_chg != '0) begin
            if (q.size() == 0) begin
                check("unexpected_pulse_chg", 32'(sw_chg), 32'(0));
            end else begin
                e = q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.at));
                check("pulse_clean", 32'(sw_clean), 32'(e.clean));
                check("pulse_chg", 32'(sw_chg), 32'(e.chg));
                check("pulse_any", 32'(sw_any_chg), 32'(1));
            end
        end
    end

    initial begin
        // Reset hold
        #500;
        check("rst_clean", 32'(sw_clean), 32'hf);
        check("rst_chg", 32'(sw_chg), 32'h0);
        check("rst_any", 32'(sw_any_chg), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        wait_cycles(20);
        check("post_rst_clean", 32'(sw_clean), 32'hf);

        // Clean step f -> 8
        drive(4'h8, 1'b1);
        wait_cycles(LAT - 1);
        check("step_before", 32'(sw_clean), 32'hf);
        wait_cycles(1);
        check("step_after", 32'(sw_clean), 32'h8);
        wait_cycles(20);

        // Short glitch on bit0
        drive(4'h9, 1'b0);
        wait_cycles(5);
        drive(4'h8, 1'b0);
        wait_cycles(20);
        check("glitch_clean", 32'(sw_clean), 32'h8);

        // Bounce on bit1, then settle e -> c
        drive(4'he, 1'b1);
        wait_cycles(20);
        for (int i = 0; i < 10; i++) begin
            drive(sw_raw ^ 4'h2, 1'b0);
            wait_cycles(3);
        end
        drive(4'hc, 1'b1);
        wait_cycles(LAT - 1);
        check("bounce_before", 32'(sw_clean), 32'he);
        wait_cycles(1);
        check("bounce_after", 32'(sw_clean), 32'hc);
        wait_cycles(20);

        // Reset mid-count f -> 2
        drive(4'hf, 1'b1);
        wait_cycles(20);
        drive(4'h2, 1'b0);
        wait_cycles(5);
        resetn = 1'b0;
        acc    = 4'hf;
        #1;
        check("midrst_clean", 32'(sw_clean), 32'hf);
        check("midrst_chg", 32'(sw_chg), 32'h0);
        check("midrst_any", 32'(sw_any_chg), 32'h0);
        wait_cycles(3);
        resetn = 1'b1;
        push(4'h2, 4'h2 ^ acc, cyc + LAT);
        acc = 4'h2;
        wait_cycles(LAT - 1);
        check("midrst_before", 32'(sw_clean), 32'hf);
        wait_cycles(1);
        check("midrst_after", 32'(sw_clean), 32'h2);
        wait_cycles(20);

        // All bits change together 2 -> d
        drive(4'hd, 1'b1);
        wait_cycles(LAT + 10);
        check("simul_clean", 32'(sw_clean), 32'hd);

        wait_cycles(5);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
